// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner and req/ack instruction fetch with timeout fault
module instr_fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
    parameter int                TIMEOUT  = 15
) (
    input  logic              I_clk,
    input  logic              I_reset_n,
    input  logic              I_enfetch,
    input  logic              I_pc_load,
    input  logic [ADDR_W-1:0] I_pc_target,
    output logic              O_imem_req,
    output logic [ADDR_W-1:0] O_imem_addr,
    input  logic              I_imem_ack,
    input  logic [DATA_W-1:0] I_imem_data,
    output logic [DATA_W-1:0] O_instr,
    output logic              O_instr_valid,
    output logic [ADDR_W-1:0] O_pc,
    output logic              O_busy,
    output logic              O_overrun,
    output logic              O_fault
);
    localparam int         CW      = $clog2(TIMEOUT + 1);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_FAULT = 2'd2;
    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic              pend;
    logic [ADDR_W-1:0] pend_pc;
    // fetch FSM: issue request, hold it until ack or timeout, then advance PC
    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            state         <= S_IDLE;
            cnt           <= '0;
            pend          <= 1'b0;
            pend_pc       <= '0;
            O_pc          <= RESET_PC;
            O_imem_req    <= 1'b0;
            O_imem_addr   <= '0;
            O_instr       <= '0;
            O_instr_valid <= 1'b0;
            O_busy        <= 1'b0;
            O_overrun     <= 1'b0;
            O_fault       <= 1'b0;
        end else begin
            O_instr_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (I_pc_load)
                        O_pc <= I_pc_target;
                    if (I_enfetch) begin
                        state       <= S_REQ;
                        O_imem_req  <= 1'b1;
                        O_busy      <= 1'b1;
                        cnt         <= '0;
                        O_imem_addr <= I_pc_load ? I_pc_target : O_pc;
                    end
                end
                S_REQ: begin
                    if (I_enfetch)
                        O_overrun <= 1'b1;
                    if (I_pc_load) begin
                        pend    <= 1'b1;
                        pend_pc <= I_pc_target;
                    end
                    if (I_imem_ack) begin
                        state         <= S_IDLE;
                        O_instr       <= I_imem_data;
                        O_instr_valid <= 1'b1;
                        O_imem_req    <= 1'b0;
                        O_busy        <= 1'b0;
                        pend          <= 1'b0;
                        O_pc          <= I_pc_load ? I_pc_target : pend ? pend_pc : O_pc + 1'b1;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        state      <= S_FAULT;
                        O_imem_req <= 1'b0;
                        O_fault    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_FAULT: begin
                    if (I_enfetch)
                        O_overrun <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed fetch scenarios with a scoreboard-driven valid monitor
module tb_instr_fetch_unit;
    logic        I_clk = 1'b0, I_reset_n = 1'b0, I_enfetch = 1'b0, I_pc_load = 1'b0, I_imem_ack = 1'b0;
    logic [15:0] I_pc_target = '0, I_imem_data = '0;
    logic        O_imem_req, O_instr_valid, O_busy, O_overrun, O_fault;
    logic [15:0] O_imem_addr, O_instr, O_pc;
    int          checks = 0, errors = 0, mchk = 0, merr = 0;
    logic [31:0] sb[$];

    instr_fetch_unit dut (
        .I_clk(I_clk), .I_reset_n(I_reset_n), .I_enfetch(I_enfetch), .I_pc_load(I_pc_load),
        .I_pc_target(I_pc_target), .O_imem_req(O_imem_req), .O_imem_addr(O_imem_addr),
        .I_imem_ack(I_imem_ack), .I_imem_data(I_imem_data), .O_instr(O_instr),
        .O_instr_valid(O_instr_valid), .O_pc(O_pc), .O_busy(O_busy),
        .O_overrun(O_overrun), .O_fault(O_fault)
    );

    always #5 I_clk = ~I_clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge I_clk);
    endtask

    task automatic load_pc(input logic [15:0] t);
        I_pc_load = 1'b1;
        I_pc_target = t;
        cyc();
        I_pc_load = 1'b0;
        chk("pc_load", O_pc, t);
    endtask

    // monitor: every valid strobe must match the oldest expected {instr, pc}
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge I_clk);
            if (I_reset_n && O_instr_valid) begin
                mchk++;
                if (sb.size() == 0) begin
                    merr++;
                    $display("FAIL unexpected_valid: got valid=1 instr=%h expected valid=0", O_instr);
                end else begin
                    e = sb.pop_front();
                    if ({O_instr, O_pc} !== e) begin
                        merr++;
                        $display("FAIL strobe: got instr=%h pc=%h expected instr=%h pc=%h",
                                 O_instr, O_pc, e[31:16], e[15:0]);
                    end
                end
            end
        end
    end

    initial begin
        cyc();
        cyc();
        chk("rst_pc", O_pc, 16'h0000);
        chk("rst_req", O_imem_req, 0);
        chk("rst_addr", O_imem_addr, 16'h0000);
        chk("rst_instr", O_instr, 16'h0000);
        chk("rst_valid", O_instr_valid, 0);
        chk("rst_busy", O_busy, 0);
        chk("rst_overrun", O_overrun, 0);
        chk("rst_fault", O_fault, 0);
        I_reset_n = 1'b1;
        cyc();
        // zero-wait fetch
        I_enfetch = 1'b1;
        sb.push_back({16'hA5C3, 16'h0001});
        cyc();
        I_enfetch = 1'b0;
        chk("zw_req", O_imem_req, 1);
        chk("zw_addr", O_imem_addr, 16'h0000);
        chk("zw_busy", O_busy, 1);
        I_imem_ack = 1'b1;
        I_imem_data = 16'hA5C3;
        cyc();
        I_imem_ack = 1'b0;
        chk("zw_req_drop", O_imem_req, 0);
        chk("zw_valid", O_instr_valid, 1);
        chk("zw_pc", O_pc, 16'h0001);
        cyc();
        chk("zw_valid_once", O_instr_valid, 0);
        chk("zw_instr_hold", O_instr, 16'hA5C3);
        // wait states with overrun
        I_enfetch = 1'b1;
        sb.push_back({16'h1234, 16'h0002});
        cyc();
        chk("ws_req", O_imem_req, 1);
        chk("ws_addr", O_imem_addr, 16'h0001);
        for (int i = 0; i < 3; i++) begin
            cyc();
            I_enfetch = 1'b0;
            chk("ws_req_hold", O_imem_req, 1);
            chk("ws_addr_hold", O_imem_addr, 16'h0001);
        end
        chk("ws_overrun", O_overrun, 1);
        I_imem_ack = 1'b1;
        I_imem_data = 16'h1234;
        cyc();
        I_imem_ack = 1'b0;
        chk("ws_pc", O_pc, 16'h0002);
        cyc();
        chk("ws_overrun_sticky", O_overrun, 1);
        // branch during fetch
        load_pc(16'h0010);
        I_enfetch = 1'b1;
        sb.push_back({16'hBEEF, 16'h0300});
        cyc();
        I_enfetch = 1'b0;
        chk("br_addr", O_imem_addr, 16'h0010);
        I_pc_load = 1'b1;
        I_pc_target = 16'h0200;
        cyc();
        I_pc_target = 16'h0300;
        cyc();
        I_pc_load = 1'b0;
        chk("br_addr_hold", O_imem_addr, 16'h0010);
        chk("br_pc_hold", O_pc, 16'h0010);
        I_imem_ack = 1'b1;
        I_imem_data = 16'hBEEF;
        cyc();
        I_imem_ack = 1'b0;
        chk("br_pc", O_pc, 16'h0300);
        cyc();
        // simultaneous load and enfetch in idle
        load_pc(16'h0005);
        I_pc_load = 1'b1;
        I_pc_target = 16'h0040;
        I_enfetch = 1'b1;
        sb.push_back({16'hC0DE, 16'h0041});
        cyc();
        I_pc_load = 1'b0;
        I_enfetch = 1'b0;
        chk("ld_addr", O_imem_addr, 16'h0040);
        chk("ld_req", O_imem_req, 1);
        I_imem_ack = 1'b1;
        I_imem_data = 16'hC0DE;
        cyc();
        I_imem_ack = 1'b0;
        chk("ld_pc", O_pc, 16'h0041);
        cyc();
        // wrap with ack on the 15th request cycle
        load_pc(16'hFFFF);
        I_enfetch = 1'b1;
        sb.push_back({16'h7777, 16'h0000});
        cyc();
        I_enfetch = 1'b0;
        chk("wr_addr", O_imem_addr, 16'hFFFF);
        for (int i = 0; i < 14; i++) begin
            cyc();
            chk("wr_req_hold", O_imem_req, 1);
        end
        I_imem_ack = 1'b1;
        I_imem_data = 16'h7777;
        cyc();
        I_imem_ack = 1'b0;
        chk("wr_pc", O_pc, 16'h0000);
        chk("wr_fault", O_fault, 0);
        chk("wr_busy", O_busy, 0);
        cyc();
        // timeout with no ack
        I_enfetch = 1'b1;
        cyc();
        I_enfetch = 1'b0;
        for (int i = 0; i < 14; i++) begin
            cyc();
            chk("to_req_hold", O_imem_req, 1);
            chk("to_no_fault", O_fault, 0);
        end
        cyc();
        chk("to_fault", O_fault, 1);
        chk("to_req", O_imem_req, 0);
        chk("to_busy", O_busy, 1);
        I_enfetch = 1'b1;
        I_pc_load = 1'b1;
        I_pc_target = 16'h1234;
        I_imem_ack = 1'b1;
        cyc();
        I_enfetch = 1'b0;
        I_pc_load = 1'b0;
        I_imem_ack = 1'b0;
        cyc();
        chk("ft_req", O_imem_req, 0);
        chk("ft_pc", O_pc, 16'h0000);
        chk("ft_fault_sticky", O_fault, 1);
        chk("ft_busy", O_busy, 1);
        // leave fault via reset
        I_reset_n = 1'b0;
        cyc();
        I_reset_n = 1'b1;
        chk("rr_fault", O_fault, 0);
        chk("rr_overrun", O_overrun, 0);
        chk("rr_busy", O_busy, 0);
        // async reset mid-request
        load_pc(16'h0020);
        I_enfetch = 1'b1;
        cyc();
        I_enfetch = 1'b0;
        chk("ar_req_pre", O_imem_req, 1);
        #2 I_reset_n = 1'b0;
        #1;
        chk("ar_req", O_imem_req, 0);
        chk("ar_busy", O_busy, 0);
        chk("ar_valid", O_instr_valid, 0);
        chk("ar_pc", O_pc, 16'h0000);
        I_imem_ack = 1'b1;
        I_imem_data = 16'hDEAD;
        cyc();
        cyc();
        I_reset_n = 1'b1;
        cyc();
        cyc();
        I_imem_ack = 1'b0;
        chk("ar_req_post", O_imem_req, 0);
        chk("ar_valid_post", O_instr_valid, 0);
        chk("ar_instr_post", O_instr, 16'h0000);
        chk("ar_pc_post", O_pc, 16'h0000);
        repeat (3) cyc();
        chk("sb_empty", sb.size(), 0);
        checks += mchk;
        errors += merr;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction fetch stage for the 16-bit RISC core. It sits directly downstream of the one-hot control sequencer and consumes its fetch-enable pulse.
- Owns the program counter and runs a req/ack read on instruction memory. It presents the fetched word to the decode stage with a one-cycle valid strobe.
- Branch/jump targets are loaded from the register-write/ALU side.

Parameters:
ADDR_W, 16, PC and instruction-memory address width
DATA_W, 16, instruction word width
RESET_PC, 16'h0000, PC value after reset
TIMEOUT, 15, max consecutive REQ cycles without ack before fault (>=1)

Ports:
I_clk  in  1  clock, rising edge
I_reset_n  in  1  asynchronous active-low reset
I_enfetch  in  1  fetch-enable pulse from control sequencer
I_pc_load  in  1  load PC with I_pc_target (branch/jump)
I_pc_target  in  ADDR_W  branch/jump target address
O_imem_req  out  1  instruction memory read request
O_imem_addr  out  ADDR_W  instruction memory address
I_imem_ack  in  1  memory data valid, sampled only while O_imem_req=1
I_imem_data  in  DATA_W  instruction word, captured on ack
O_instr  out  DATA_W  last fetched instruction (held)
O_instr_valid  out  1  one-cycle strobe: O_instr updated
O_pc  out  ADDR_W  current PC
O_busy  out  1  fetch in progress or faulted
O_overrun  out  1  sticky: I_enfetch arrived while busy
O_fault  out  1  sticky: memory timeout

Behaviour:
- Reset (I_reset_n=0, async assert, sync release):
  - O_pc=RESET_PC; O_imem_req=0; O_imem_addr=0; O_instr=0.
  - O_instr_valid, O_busy, O_overrun and O_fault all 0.
  - Pending-load flag cleared; FSM=IDLE; wait counter=0.
  - Reset mid-fetch abandons the request immediately and produces no valid strobe.
- All outputs are registered. PC arithmetic is modulo 2^ADDR_W, so 16'hFFFF+1 wraps to 16'h0000. The PC is word-addressed: increment by 1.
- FSM states: IDLE, REQ, FAULT.
- IDLE:
  - O_imem_req=0, O_busy=0.
  - I_pc_load alone: O_pc<=I_pc_target next cycle.
  - I_enfetch=1: next state REQ; O_imem_req<=1; O_busy<=1; counter<=0.
    - O_imem_addr<=I_pc_target if I_pc_load is asserted in the same cycle (the load wins and is the fetched address). In that case O_pc<=I_pc_target too.
    - Otherwise O_imem_addr<=O_pc.
- REQ:
  - O_imem_req and O_imem_addr are held stable until ack.
  - I_imem_ack=1:
    - O_instr<=I_imem_data; O_instr_valid<=1 for exactly one cycle; O_imem_req<=0; O_busy<=0; state IDLE.
    - O_pc<=pending target if the pending-load flag is set (flag cleared), else O_pc+1.
  - No ack: counter increments. If counter==TIMEOUT-1 with no ack, go to FAULT. An ack on that same cycle wins; no fault.
  - I_pc_load in REQ: target stored in the pending register with the flag set. The last load before ack wins.
  - I_enfetch in REQ: ignored; O_overrun<=1 (sticky).
- FAULT:
  - O_imem_req=0, O_busy=1, O_fault=1.
  - I_enfetch is ignored and sets O_overrun. I_pc_load is ignored.
  - Exit only by reset.
- Latency: I_enfetch at cycle N gives O_imem_req=1 from N+1. Ack sampled at cycle M gives O_instr_valid=1 and the updated O_pc at M+1. With zero-wait memory (ack at N+1), valid is at N+2.
- I_imem_ack while O_imem_req=0 is ignored.
- O_instr holds its value between strobes.

Test Plan:
- Zero-wait fetch: reset, enfetch at cycle 2, mem acks 16'hA5C3 on the first req cycle.
  - Required: req high at cycle 3 only, addr 16'h0000.
  - Required at cycle 4: O_instr=16'hA5C3 with valid high for that cycle only, O_pc=16'h0001.
- Wait states plus overrun: ack delayed 3 cycles, enfetch re-pulsed during REQ.
  - Required: addr held stable throughout; valid fires once; O_overrun=1 and stays set; O_pc increments by exactly 1.
- Branch during fetch: PC=16'h0010, enfetch, then I_pc_load with 16'h0200 and then 16'h0300 before ack.
  - Required: fetch uses 16'h0010; after ack O_pc=16'h0300.
- Simultaneous load+enfetch in IDLE: PC=16'h0005, I_pc_load=1 with target 16'h0040 and enfetch in the same cycle.
  - Required: O_imem_addr=16'h0040; after ack O_pc=16'h0041.
- Wrap and timeout: PC=16'hFFFF, ack on the last allowed cycle (15th REQ cycle).
  - Required: valid fires, O_pc=16'h0000, O_fault=0.
  - Next fetch with no ack: O_fault=1 after 15 REQ cycles, req=0, busy=1, no valid. Later enfetch is ignored.
- Async reset mid-REQ: drop I_reset_n between clock edges.
  - Required: req, busy and valid are 0 immediately; O_pc=RESET_PC; no strobe after release.
